// File: rtl/wb_stage_skid_reg.sv
// MEM/WB boundary register with valid/ready handshake and a two-entry skid
// buffer. The main register drives the outputs directly; the skid register
// absorbs one overflow entry so in_ready can be a registered signal.
// Flush kills all held entries, and a saturating counter reports how many
// valid entries were killed.
module wb_stage_skid_reg #(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 5,
  parameter int SEL_W      = 1,
  parameter int ZERO_GUARD = 1,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_wb_addr,
  input  logic                     in_wb_en,
  input  logic [SEL_W-1:0]         in_wb_sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_wb_addr,
  output logic                     out_wb_en,
  output logic [SEL_W-1:0]         out_wb_sel,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         flush_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0]        addr;
    logic                     en;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH*DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t           state, state_nxt;
  entry_t           main_q, skid_q, main_nxt, skid_nxt, in_ent;
  logic             ready_q, wb_en_q, wb_en_nxt;
  logic             in_fire, out_fire;
  logic [1:0]       killed;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  assign in_ent   = '{addr: in_wb_addr, en: in_wb_en, sel: in_wb_sel, data: in_data};
  assign in_fire  = in_valid & ready_q;
  assign out_fire = (state != EMPTY) & out_ready;

  // Next-state, payload steering and count of entries killed by a flush
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    killed    = 2'd0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = FULL;
          main_nxt  = in_ent;
        end
      end
      FULL: begin
        killed = out_fire ? 2'd0 : 2'd1;
        if (in_fire && out_fire) begin
          main_nxt = in_ent;
        end else if (in_fire) begin
          state_nxt = SKID;
          skid_nxt  = in_ent;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        killed = out_fire ? 2'd1 : 2'd2;
        if (out_fire) begin
          state_nxt = FULL;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins: drop everything, leave payloads stale
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
    end
  end

  // Saturating flush counter update
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(killed);
    cnt_nxt = cnt_q;
    if (flush) cnt_nxt = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  // Write enable is precomputed from the next main entry so it leaves a flop
  always_comb begin
    wb_en_nxt = (state_nxt != EMPTY) & main_nxt.en &
                !((ZERO_GUARD != 0) && (main_nxt.addr == '0));
  end

  // Control state, registered ready, write enable and counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
      wb_en_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != SKID);
      wb_en_q <= wb_en_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Payload registers; hold while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = (state != EMPTY);
  assign out_wb_addr = main_q.addr;
  assign out_wb_en   = wb_en_q;
  assign out_wb_sel  = main_q.sel;
  assign out_data    = main_q.data;
  assign flush_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_stage_skid_reg.sv
// Bench for wb_stage_skid_reg: directed vector table, async reset corner,
// randomized traffic against a queue model, and counter saturation on a
// narrow-counter instance.
module tb_wb_stage_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv, ordy, fl, en;
  logic [4:0]  addr;
  logic        sel;
  logic [63:0] din;
  logic        ov, ir, owe, osel;
  logic [4:0]  oaddr;
  logic [63:0] dout;
  logic [15:0] cnt;

  logic        s_iv, s_ordy, s_fl, s_ov, s_ir, s_owe, s_osel;
  logic [4:0]  s_oaddr;
  logic [63:0] s_dout;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_skid_reg dut (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir),
    .in_wb_addr(addr), .in_wb_en(en), .in_wb_sel(sel), .in_data(din),
    .flush(fl), .out_valid(ov), .out_ready(ordy), .out_wb_addr(oaddr),
    .out_wb_en(owe), .out_wb_sel(osel), .out_data(dout), .flush_cnt(cnt)
  );

  wb_stage_skid_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_iv), .in_ready(s_ir),
    .in_wb_addr(5'd7), .in_wb_en(1'b1), .in_wb_sel(1'b0), .in_data(64'h0),
    .flush(s_fl), .out_valid(s_ov), .out_ready(s_ordy), .out_wb_addr(s_oaddr),
    .out_wb_en(s_owe), .out_wb_sel(s_osel), .out_data(s_dout), .flush_cnt(s_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic iv, ordy, fl, en;
    logic [4:0] a;
    logic [31:0] d;
    logic eov, eir, eowe;
    logic [4:0] ea;
    logic [31:0] ed;
    int ecnt;
  } vec_t;

  function automatic vec_t mkv(logic v, logic r, logic f, logic e, logic [4:0] a,
                               logic [31:0] d, logic eov, logic eir, logic eowe,
                               logic [4:0] ea, logic [31:0] ed, int ecnt);
    vec_t t;
    t.iv = v; t.ordy = r; t.fl = f; t.en = e; t.a = a; t.d = d;
    t.eov = eov; t.eir = eir; t.eowe = eowe; t.ea = ea; t.ed = ed; t.ecnt = ecnt;
    return t;
  endfunction

  typedef struct {
    logic [4:0]  a;
    logic        e;
    logic        s;
    logic [63:0] d;
  } ent_t;

  vec_t tbl[24];
  ent_t q[$];
  ent_t ne;
  logic m_ir;
  int   m_cnt;
  int   k;

  initial begin
    // streaming
    tbl[0]  = mkv(1,1,0,1, 1,32'h10, 1,1,1, 1,32'h10, 0);
    tbl[1]  = mkv(1,1,0,1, 2,32'h11, 1,1,1, 2,32'h11, 0);
    tbl[2]  = mkv(1,1,0,1, 3,32'h12, 1,1,1, 3,32'h12, 0);
    tbl[3]  = mkv(1,1,0,1, 4,32'h13, 1,1,1, 4,32'h13, 0);
    tbl[4]  = mkv(0,1,0,1, 0,32'h0,  0,1,0, 0,32'h0,  0);
    // backpressure into SKID, then drain
    tbl[5]  = mkv(1,0,0,1, 3,32'hA,  1,1,1, 3,32'hA,  0);
    tbl[6]  = mkv(1,0,0,1, 4,32'hB,  1,0,1, 3,32'hA,  0);
    tbl[7]  = mkv(1,0,0,1, 5,32'hC,  1,0,1, 3,32'hA,  0);
    tbl[8]  = mkv(0,1,0,1, 0,32'h0,  1,1,1, 4,32'hB,  0);
    tbl[9]  = mkv(0,1,0,0, 0,32'h0,  0,1,0, 0,32'h0,  0);
    // flush in SKID with out_ready=0
    tbl[10] = mkv(1,0,0,1, 6,32'h20, 1,1,1, 6,32'h20, 0);
    tbl[11] = mkv(1,0,0,1, 7,32'h21, 1,0,1, 6,32'h20, 0);
    tbl[12] = mkv(1,0,1,1, 8,32'hC,  0,1,0, 0,32'h0,  2);
    tbl[13] = mkv(0,1,0,0, 0,32'h0,  0,1,0, 0,32'h0,  2);
    // flush in FULL with out_fire: nothing killed
    tbl[14] = mkv(1,1,0,1, 9,32'h30, 1,1,1, 9,32'h30, 2);
    tbl[15] = mkv(0,1,1,0, 0,32'h0,  0,1,0, 0,32'h0,  2);
    // x0 guard and write-enable qualification
    tbl[16] = mkv(1,1,0,1, 0,32'h40, 1,1,0, 0,32'h40, 2);
    tbl[17] = mkv(1,1,0,0,10,32'h41, 1,1,0,10,32'h41, 2);
    tbl[18] = mkv(1,1,0,1,10,32'h42, 1,1,1,10,32'h42, 2);
    tbl[19] = mkv(0,1,0,1,11,32'h43, 0,1,0, 0,32'h0,  2);
    // flush in FULL without out_fire, then flush discarding an in_fire
    tbl[20] = mkv(1,0,0,1,12,32'h50, 1,1,1,12,32'h50, 2);
    tbl[21] = mkv(0,0,1,0, 0,32'h0,  0,1,0, 0,32'h0,  3);
    tbl[22] = mkv(1,1,1,1,13,32'h60, 0,1,0, 0,32'h0,  3);
    tbl[23] = mkv(0,1,0,0, 0,32'h0,  0,1,0, 0,32'h0,  3);

    iv = 0; ordy = 0; fl = 0; en = 0; addr = 0; sel = 0; din = 0;
    s_iv = 0; s_ordy = 0; s_fl = 0;
    reset = 0;
    #12;
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_wb_en", 64'(owe), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_data", dout, 64'd0);
    reset = 1;
    cyc();
    chk("rst_in_ready_first_edge", 64'(ir), 64'd1);

    foreach (tbl[i]) begin
      iv = tbl[i].iv; ordy = tbl[i].ordy; fl = tbl[i].fl; en = tbl[i].en;
      addr = tbl[i].a; sel = tbl[i].a[0]; din = {~tbl[i].d, tbl[i].d};
      cyc();
      chk($sformatf("v%0d_out_valid", i), 64'(ov), 64'(tbl[i].eov));
      chk($sformatf("v%0d_in_ready", i), 64'(ir), 64'(tbl[i].eir));
      chk($sformatf("v%0d_wb_en", i), 64'(owe), 64'(tbl[i].eowe));
      chk($sformatf("v%0d_cnt", i), 64'(cnt), 64'(tbl[i].ecnt));
      if (tbl[i].eov) begin
        chk($sformatf("v%0d_addr", i), 64'(oaddr), 64'(tbl[i].ea));
        chk($sformatf("v%0d_sel", i), 64'(osel), 64'(tbl[i].ea[0]));
        chk($sformatf("v%0d_data", i), dout, {~tbl[i].ed, tbl[i].ed});
      end
    end

    // async reset mid-SKID, between edges
    iv = 1; ordy = 0; fl = 0; en = 1; addr = 5'd20; din = 64'h1;
    cyc();
    addr = 5'd21; din = 64'h2;
    cyc();
    chk("skid_in_ready", 64'(ir), 64'd0);
    iv = 0;
    #2 reset = 0;
    #1;
    chk("async_out_valid", 64'(ov), 64'd0);
    chk("async_wb_en", 64'(owe), 64'd0);
    chk("async_cnt", 64'(cnt), 64'd0);
    #2 reset = 1;
    cyc();
    chk("release_in_ready", 64'(ir), 64'd1);
    chk("release_out_valid", 64'(ov), 64'd0);

    // randomized traffic against a queue model
    q.delete(); m_ir = 1'b1; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 15) == 0);
      en   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      sel  = 1'($urandom);
      din  = {$urandom, $urandom};
      ne.a = addr; ne.e = en; ne.s = sel; ne.d = din;
      if (fl) begin
        k = q.size() - ((q.size() > 0 && ordy) ? 1 : 0);
        m_cnt = (m_cnt + k > 65535) ? 65535 : m_cnt + k;
        q.delete();
      end else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (iv && m_ir) q.push_back(ne);
      end
      m_ir = (q.size() < 2);
      cyc();
      chk("rnd_out_valid", 64'(ov), 64'(q.size() > 0));
      chk("rnd_in_ready", 64'(ir), 64'(m_ir));
      chk("rnd_cnt", 64'(cnt), 64'(m_cnt));
      if (q.size() > 0) begin
        chk("rnd_wb_en", 64'(owe), 64'(q[0].e && q[0].a != 0));
        chk("rnd_addr", 64'(oaddr), 64'(q[0].a));
        chk("rnd_sel", 64'(osel), 64'(q[0].s));
        chk("rnd_data", dout, q[0].d);
      end else begin
        chk("rnd_wb_en_idle", 64'(owe), 64'd0);
      end
    end
    iv = 0; fl = 0;

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 3; i++) begin
      s_iv = 1; s_fl = 0; s_ordy = 0;
      cyc();
      s_iv = 0; s_fl = 1;
      cyc();
      chk($sformatf("sat_single_%0d", i), 64'(s_cnt), 64'(i + 1));
    end
    s_iv = 1; s_fl = 0;
    cyc();
    cyc();
    chk("sat_skid_ready", 64'(s_ir), 64'd0);
    s_iv = 0; s_fl = 1;
    cyc();
    chk("sat_double", 64'(s_cnt), 64'd3);
    chk("sat_out_valid", 64'(s_ov), 64'd0);
    s_fl = 0;
    cyc();
    chk("sat_hold", 64'(s_cnt), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_skid_reg.md
Name: wb_stage_skid_reg

Overview:
- Parametrised MEM/WB pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer.
- Carries a write-back address, write enable, result-select and NUM_CH data channels of DATA_W bits each.
- Supports hazard-unit flush and qualifies the write enable with valid, so bubbles never write the register file.
- Sits between the memory-access stage and write-back. A saturating counter of flushed entries feeds the performance-counter block.

Parameters:
DATA_W, 32, width of each data channel
NUM_CH, 2, number of data channels (ch0 = ALU result, ch1 = data-memory result)
ADDR_W, 5, register-file write-address width
SEL_W, 1, write-back mux select width
ZERO_GUARD, 1, when 1 force write enable low for address 0
CNT_W, 16, width of flush counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept (registered)
in_wb_addr  in  ADDR_W  destination register
in_wb_en  in  1  register write enable
in_wb_sel  in  SEL_W  write-back mux select
in_data  in  NUM_CH*DATA_W  channels, ch0 in LSBs
flush  in  1  synchronous kill of all held entries
out_valid  out  1  output entry valid
out_ready  in  1  write-back consumes entry
out_wb_addr  out  ADDR_W  registered address
out_wb_en  out  1  qualified write enable
out_wb_sel  out  SEL_W  registered select
out_data  out  NUM_CH*DATA_W  registered channels
flush_cnt  out  CNT_W  saturating count of valid entries killed by flush

Behaviour:
- Reset (reset=0, asynchronous): state EMPTY; all payload registers, out_valid, out_wb_en and flush_cnt = 0; in_ready = 1 from the first clock edge after deassertion.
- Storage:
  - main register drives out_* directly.
  - skid register holds one overflow entry.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payload is held stable while out_valid & !out_ready.
- in_ready = (state != SKID). It is registered and combinationally independent of out_ready.
- States and transitions (no flush):
  - EMPTY: in_fire -> FULL, main <= in.
  - FULL, in_fire & out_fire: stay FULL, main <= in.
  - FULL, in_fire & !out_fire: -> SKID, skid <= in.
  - FULL, !in_fire & out_fire: -> EMPTY.
  - SKID, out_fire: -> FULL, main <= skid. No input can be accepted in SKID.
- out_valid = (state != EMPTY). Latency from in_fire to out_valid is 1 cycle when the stage is EMPTY or draining.
- Flush (highest priority, synchronous):
  - next state = EMPTY.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed; that entry is not counted as killed.
  - Payload registers keep stale values; only valids clear.
- flush_cnt on a flush cycle:
  - Increments by the number of valid entries killed: 0, 1 (FULL without out_fire, or SKID with out_fire) or 2 (SKID without out_fire).
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- out_wb_en = out_valid & main_wb_en & !(ZERO_GUARD && out_wb_addr == 0). Registered, with no combinational path from in_*.
- All data channels are copied bit-exact with no arithmetic. Channel k occupies bits [k*DATA_W +: DATA_W].
- Reset asserted mid-operation: immediate return to the reset values above; skid contents are lost.

Test Plan:
- Streaming, out_ready=1, in_valid=1 for 4 cycles with addr 1..4, ch0=0x10..0x13: out_valid 1 cycle later each, same order, in_ready stays 1, no SKID entry.
- Backpressure: out_ready=0, push A (addr 3) then B (addr 4): state SKID, in_ready=0, out holds A; raise out_ready: A then B emerge on consecutive cycles, in_ready=1 again.
- Flush in SKID with out_ready=0 and in_valid=1 carrying C: out_valid=0 next cycle, C never appears, flush_cnt increments by 2; repeat in FULL with out_ready=1: flush_cnt unchanged.
- Bubbles and x0: in_wb_en=1 with addr 0 under ZERO_GUARD=1 -> out_wb_en=0; entry with in_valid=0 -> out_wb_en=0 while out_valid=0.
- Counter saturation with CNT_W=2: 3 single-entry flushes then a 2-entry flush -> flush_cnt=3 and stays 3.
- Async reset asserted mid-SKID, between clock edges: out_valid, out_wb_en and flush_cnt = 0 immediately; after release, in_ready=1 on the first edge.
